// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for the team FIFO. It issues pops, captures the read data one cycle
// later, and presents the words as a valid/ready stream through a 2-entry in-order buffer.
// It sustains one word per cycle under arbitrary backpressure, with no loss or duplication.
// Optional fixed-length framing raises m_last on every PACKET_LEN-th transferred word.
//
// Parameters:
//   DATA_SIZE   word width; must match the FIFO
//   PACKET_LEN  words per packet for m_last; 0 disables framing (m_last held 0)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset, shared with the FIFO
//   en            in   allows new pops; in-flight data is still captured when low
//   fifo_empty    in   FIFO empty flag
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_pop
//   fifo_pop      out  pop strobe to the FIFO (combinational)
//   m_valid       out  output word valid
//   m_ready       in   downstream accept
//   m_data        out  output word (buffer head)
//   m_last        out  final word of a packet, qualified by m_valid
//   busy          out  buffer holds words or a pop is in flight
module fifo_stream_reader #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned PACKET_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_pop,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int unsigned PktW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  logic [1:0]           count_q, count_d;
  logic                 inflight_q;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;
  logic                 deq;
  logic [2:0]           occ_after_deq;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = head_q;
  assign deq     = m_valid & m_ready;
  assign busy    = m_valid | inflight_q;

  // Words held or owed to the buffer once this cycle's transfer leaves. deq implies
  // count_q >= 1, so the subtraction cannot wrap. This is the only m_ready -> fifo_pop path.
  assign occ_after_deq = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
  assign fifo_pop      = en & ~fifo_empty & (occ_after_deq < 3'd2);

  // Buffer next state: head_q is the oldest word, tail_q the second one.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({inflight_q, deq})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = fifo_rd_data;
        end else begin
          tail_d = fifo_rd_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Capture and transfer together: occupancy unchanged, order preserved.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = fifo_rd_data;
        end else begin
          head_d = fifo_rd_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= fifo_pop;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  if (PACKET_LEN > 0) begin : g_frame
    localparam logic [PktW-1:0] PktMax = PktW'(PACKET_LEN - 1);
    logic [PktW-1:0] pkt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pkt_q <= '0;
      end else if (deq) begin
        pkt_q <= (pkt_q == PktMax) ? '0 : pkt_q + PktW'(1);
      end
    end

    assign m_last = m_valid & (pkt_q == PktMax);
  end else begin : g_no_frame
    assign m_last = 1'b0;
  end

  // The pop rule must keep the buffer within two entries and never pop an empty FIFO.
  a_count_max: assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(inflight_q && !deq && (count_q == 2'd2)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) fifo_pop |-> !fifo_empty);

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side master for the team's FIFO: it drives the FIFO's pop and empty interface and presents the popped words as a valid/ready stream. Pop data arrives one cycle after the pop strobe, so the block tracks in-flight reads and holds them in a 2-entry output buffer. This sustains 1 word/cycle with no loss or duplication under arbitrary backpressure. Optional fixed-length framing asserts m_last on every PACKET_LEN-th transferred word.

Parameters:
DATA_SIZE, 8, word width; must match the FIFO.
PACKET_LEN, 4, words per packet for m_last generation; 0 disables framing (m_last held 0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high; shared with the FIFO.
en  input  1  allows new pops; in-flight data is still captured when en=0.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_data  input  DATA_SIZE  FIFO read data; valid the cycle after fifo_pop.
fifo_pop  output  1  pop strobe to the FIFO; combinational.
m_valid  output  1  output word valid.
m_ready  input  1  downstream accept.
m_data  output  DATA_SIZE  output word; head of buffer.
m_last  output  1  final word of a packet; qualified by m_valid.
busy  output  1  high when the buffer holds words or a pop is in flight.

Behaviour:
- Reset, asynchronous: buffer count=0, inflight=0, packet counter=0, both buffer entries=0. Outputs: m_valid=0, m_data=0, m_last=0, busy=0, fifo_pop=0.
- Transfer ("deq") occurs when m_valid && m_ready at a rising edge.
- Pop rule, combinational: fifo_pop = en && !fifo_empty && (count + inflight - deq) < 2.
  - This is the only path from m_ready to fifo_pop.
  - fifo_pop is never asserted while fifo_empty=1.
- inflight register: set to fifo_pop each cycle. When inflight=1, fifo_rd_data is written into the buffer at the next edge.
- Buffer: 2-entry in-order queue, count 0..2.
  - m_valid = (count != 0); m_data = head entry.
  - Capture and deq in the same cycle: count unchanged, order preserved.
  - count never exceeds 2; the pop rule guarantees this. Verification asserts it.
- Latency: with empty buffer and m_ready=1, the first word is popped at cycle t, captured at t+1, and shown on m_valid/m_data from t+1 (after the t+1 edge).
- Steady state, FIFO non-empty and m_ready=1: one pop and one transfer every cycle.
- Backpressure (m_ready=0): at most 2 words accumulate in the buffer, then pops stop. Buffer contents stay stable while m_valid && !m_ready.
- en deassert: no new pops. An in-flight word is still captured. Buffered words still drain.
- Framing, PACKET_LEN>0:
  - Packet counter increments on each deq and wraps to 0 after PACKET_LEN-1.
  - m_last = m_valid && (counter == PACKET_LEN-1).
  - Counter width is clog2(PACKET_LEN), minimum 1.
  - PACKET_LEN=1 gives m_last=1 on every word.
- busy = (count != 0) || inflight.
- Reset mid-operation: all state cleared immediately and any in-flight word is discarded. Correct because the FIFO is reset by the same rst.
- fifo_rd_data is ignored whenever inflight=0.

Test Plan:
- Reset then idle: FIFO empty, en=1 for 10 cycles -> fifo_pop never 1; m_valid=0, m_data=0, m_last=0, busy=0.
- Streaming: push 0x01..0x08, m_ready=1, PACKET_LEN=4 -> m_data sequence 0x01..0x08 on consecutive cycles with no gaps after the first; m_last high on 0x04 and 0x08 only.
- Backpressure: 6 words in FIFO, m_ready=0 for 5 cycles, then 1 -> exactly 2 pops issued during the stall; m_data stays 0x01 while stalled; all 6 words delivered in order with no duplicates; the FIFO's full and empty flags stay consistent.
- Random m_ready (50%) with random FIFO pushes, 1000 words -> output order equals push order; fifo_pop never seen with fifo_empty=1; count never exceeds 2.
- en drop with a pop in flight: deassert en the cycle after a pop -> that word is still delivered; no further pops until en=1.
- Reset during stream: assert rst while count=2 and inflight=1 -> m_valid=0 and busy=0 immediately; after release with a fresh push of 0xA5 -> 0xA5 delivered first, packet counter restarted (m_last on the 4th word after reset).
